// File: rtl/mul_arbiter_pkg.sv
// mul_arbiter_pkg: shared definitions for the two-requester multiplier arbiter.
//   - state_t                 : FSM state encoding for mul_arbiter
//   - W_DEFAULT               : default operand width
//   - TIMEOUT_CYCLES_DEFAULT  : default RUN-state wait bound for mul_done
// Optional feature macro: MUL_ARBITER_TIMEOUT_EN adds the ABORT state.
package mul_arbiter_pkg;

  localparam int W_DEFAULT              = 64;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
`ifdef MUL_ARBITER_TIMEOUT_EN
    ST_RESP,
    ST_ABORT
`else
    ST_RESP
`endif
  } state_t;

endpackage

// File: rtl/mul_arbiter_rr.sv
// rr_arb2: two-way round-robin grant logic with its last-grant pointer.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   req        : per-requester request bits
//   accept     : 1 when the grant is actually taken this cycle
//   gnt        : one-hot grant (0 when nothing requested)
//   gnt_idx    : index of the granted requester
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // Index of the requester granted most recently; 1 after reset so that
  // requester 0 wins the first tie.
  logic last_q;

  always_comb begin
    gnt_idx = req[1];
    if (req == 2'b11) gnt_idx = ~last_q;
    gnt = 2'b00;
    if (req != 2'b00) gnt = gnt_idx ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (accept && (req != 2'b00)) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one multi-cycle multiplier between two requesters.
// Grants one request at a time (round-robin on ties), clears the multiplier,
// runs it until mul_done, then returns the product with a one-cycle pulse.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   req_valid / req_ready  : per-requester request and one-cycle accept pulse
//   req_a, req_b           : packed operands, requester i at [i*W +: W]
//   rsp_valid, rsp_result  : per-requester result pulse and registered product
//   rsp_err                : timeout flag, qualified by rsp_valid
//   mul_clear, mul_start   : multiplier control
//   mul_a, mul_b           : operands to the multiplier
//   mul_done, mul_result   : multiplier completion and product
// Optional feature macro: MUL_ARBITER_TIMEOUT_EN (RUN timeout -> ABORT, rsp_err).
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int W              = W_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic [1:0]     rsp_valid,
  output logic [2*W-1:0] rsp_result,
  output logic           rsp_err,
  output logic           mul_clear,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_result
);

  state_t         state_q, state_d;
  logic [1:0]     arb_gnt;
  logic           arb_idx;
  logic           take;
  logic           grant_idx_q;
  logic [W-1:0]   op_a_q, op_b_q;
  logic [2*W-1:0] result_q;

  assign take = (state_q == ST_IDLE) && (req_valid != 2'b00) && !reset;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .accept  (take),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

`ifdef MUL_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             timed_out;

  assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    mul_clear = 1'b0;
    mul_start = 1'b0;
    rsp_valid = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          req_ready = arb_gnt;
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        mul_clear = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        mul_start = 1'b1;
        if (mul_done) begin
          state_d = ST_RESP;
`ifdef MUL_ARBITER_TIMEOUT_EN
        end else if (timed_out) begin
          state_d = ST_ABORT;
`endif
        end
      end
      ST_RESP: begin
        rsp_valid = grant_idx_q ? 2'b10 : 2'b01;
        state_d   = ST_IDLE;
      end
`ifdef MUL_ARBITER_TIMEOUT_EN
      ST_ABORT: begin
        mul_clear = 1'b1;
        state_d   = ST_RESP;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign mul_a      = op_a_q;
  assign mul_b      = op_b_q;
  assign rsp_result = result_q;

  // Grant stage: capture operands of the winner; RUN stage: capture product.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        grant_idx_q <= arb_idx;
        op_a_q      <= arb_idx ? req_a[2*W-1:W] : req_a[W-1:0];
        op_b_q      <= arb_idx ? req_b[2*W-1:W] : req_b[W-1:0];
      end
      if ((state_q == ST_RUN) && mul_done) begin
        result_q <= mul_result;
`ifdef MUL_ARBITER_TIMEOUT_EN
      end else if ((state_q == ST_RUN) && timed_out) begin
        result_q <= '0;
`endif
      end
    end
  end

`ifdef MUL_ARBITER_TIMEOUT_EN
  // Counts RUN cycles without mul_done; zero everywhere else.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state_q == ST_RUN) && !mul_done) cnt_q <= cnt_q + CNT_W'(1);
      else                                  cnt_q <= '0;
      if ((state_q == ST_RUN) && mul_done)        err_q <= 1'b0;
      else if ((state_q == ST_RUN) && timed_out)  err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

  localparam int W  = 64;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a, req_b;
  logic [1:0]     rsp_valid;
  logic [2*W-1:0] rsp_result;
  logic           rsp_err;
  logic           mul_clear, mul_start;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_done;
  logic [2*W-1:0] mul_result;

  mul_arbiter #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .mul_clear  (mul_clear),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_result (mul_result)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] sprod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction

  // Multiplier environment: done after done_k cycles of mul_start (0 = never).
  int   done_k = 1;
  int   run_cnt = 0;
  logic stray_done = 1'b0;
  always @(posedge clk) begin
    if (mul_start) run_cnt <= run_cnt + 1;
    else           run_cnt <= 0;
  end
  assign mul_done   = stray_done || (mul_start && (done_k > 0) && (run_cnt == done_k - 1));
  assign mul_result = sprod(mul_a, mul_b);

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model and observation log.
  int             m_has_op = 0, m_g = 0, m_resp = 0, m_run = 0, m_idx = 0, m_last = 1;
  logic [2*W-1:0] m_res = '0, m_hold = '0;
  logic           m_err = 1'b0;
  logic [W-1:0]   m_a, m_b;
  int             gcnt0 = 0, gcnt1 = 0, clr_cnt = 0, rsp_count = 0;
  int             ready_cyc = 0, rsp_cyc = 0, last_grant = -1, prev_grant = -1;
  logic [1:0]     last_vld = '0;
  logic [2*W-1:0] last_res = '0;
  logic           last_err = 1'b0;

  initial begin : compare
    logic [1:0] e_ready, e_rsp;
    logic       e_clear, e_start;
    int         pick;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        m_has_op = 0;
        m_hold   = '0;
        m_last   = 1;
      end else begin
        e_ready = 2'b00; e_rsp = 2'b00; e_clear = 1'b0; e_start = 1'b0;
        if ((m_has_op == 0 || cyc > m_resp) && req_valid != 2'b00) begin
          if (req_valid == 2'b11) pick = 1 - m_last;
          else                    pick = req_valid[1] ? 1 : 0;
          m_last   = pick;
          m_idx    = pick;
          e_ready  = (pick == 1) ? 2'b10 : 2'b01;
          m_has_op = 1;
          m_g      = cyc;
          m_a      = (pick == 1) ? req_a[2*W-1:W] : req_a[W-1:0];
          m_b      = (pick == 1) ? req_b[2*W-1:W] : req_b[W-1:0];
          if (done_k > 0) begin
            m_run = done_k; m_resp = cyc + 2 + done_k; m_res = sprod(m_a, m_b); m_err = 1'b0;
          end else begin
`ifdef MUL_ARBITER_TIMEOUT_EN
            m_run = TO; m_resp = cyc + 3 + TO; m_res = '0; m_err = 1'b1;
`else
            m_run = 1 << 30; m_resp = 1 << 30; m_res = '0; m_err = 1'b0;
`endif
          end
        end
        if (m_has_op != 0) begin
          if (cyc == m_g + 1) e_clear = 1'b1;
          if (m_err && cyc == m_resp - 1) e_clear = 1'b1;
          if (cyc >= m_g + 2 && cyc < m_g + 2 + m_run) e_start = 1'b1;
          if (cyc == m_resp) begin
            e_rsp  = (m_idx == 1) ? 2'b10 : 2'b01;
            m_hold = m_res;
          end
        end
        chk("req_ready", 128'(req_ready), 128'(e_ready));
        chk("rsp_valid", 128'(rsp_valid), 128'(e_rsp));
        chk("mul_clear", 128'(mul_clear), 128'(e_clear));
        chk("mul_start", 128'(mul_start), 128'(e_start));
        chk("rsp_result", rsp_result, m_hold);
        if (e_start) begin
          chk("mul_a", 128'(mul_a), 128'(m_a));
          chk("mul_b", 128'(mul_b), 128'(m_b));
        end
        if (e_rsp != 2'b00) chk("rsp_err", 128'(rsp_err), 128'(m_err));
        if (req_ready != 2'b00) begin
          ready_cyc  = cyc;
          prev_grant = last_grant;
          last_grant = req_ready[1] ? 1 : 0;
          if (req_ready[0]) gcnt0++;
          if (req_ready[1]) gcnt1++;
        end
        if (mul_clear) clr_cnt++;
        if (rsp_valid != 2'b00) begin
          rsp_count++;
          rsp_cyc  = cyc;
          last_vld = rsp_valid;
          last_res = rsp_result;
          last_err = rsp_err;
        end
      end
    end
  end

  task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    bit got;
    got    = 0;
    done_k = k;
    if (idx == 0) begin req_a[W-1:0] = a; req_b[W-1:0] = b; end
    else          begin req_a[2*W-1:W] = a; req_b[2*W-1:W] = b; end
    req_valid[idx] = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL grant_wait: requester %0d got no req_ready within 50 cycles", idx);
    end
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    bit got;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      if (rsp_count >= target) got = 1;
    end
    #1;
    if (!got) begin
      checks++; errors++;
      $display("FAIL rsp_wait: rsp_count %0d never reached %0d", rsp_count, target);
    end
  endtask

  initial begin : stim
    int n0, c0, g1;
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset_req_ready", 128'(req_ready), 128'(0));
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset_mul_clear", 128'(mul_clear), 128'(0));
    chk("reset_mul_start", 128'(mul_start), 128'(0));
    chk("reset_rsp_err", 128'(rsp_err), 128'(0));
    chk("reset_rsp_result", rsp_result, 128'(0));
    chk("reset_mul_ab", 128'({mul_a, mul_b}), 128'(0));
    @(posedge clk); #1;

    // Single request, done after 4 RUN cycles.
    n0 = rsp_count; c0 = clr_cnt;
    issue(0, 64'd3, 64'd5, 4);
    wait_rsp(n0 + 1);
    chk("t1_result", last_res, 128'(15));
    chk("t1_vld", 128'(last_vld), 128'(1));
    chk("t1_clear_pulses", 128'(clr_cnt - c0), 128'(1));
    chk("t1_latency", 128'(rsp_cyc - ready_cyc), 128'(6));

    // Minimum latency, requester 1.
    n0 = rsp_count;
    issue(1, 64'd7, 64'd9, 1);
    wait_rsp(n0 + 1);
    chk("t2_result", last_res, 128'(63));
    chk("t2_vld", 128'(last_vld), 128'(2));
    chk("t2_latency", 128'(rsp_cyc - ready_cyc), 128'(3));

    // Tie held over two operations.
    n0 = rsp_count; g1 = gcnt0 + gcnt1;
    done_k = 1;
    req_a = {64'd9, 64'd6}; req_b = {64'd11, 64'd7};
    req_valid = 2'b11;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (gcnt0 + gcnt1 >= g1 + 2) break;
    end
    #1 req_valid = 2'b00;
    wait_rsp(n0 + 2);
    chk("t3_first_grant", 128'(prev_grant), 128'(0));
    chk("t3_second_grant", 128'(last_grant), 128'(1));
    chk("t3_vld", 128'(last_vld), 128'(2));
    chk("t3_result", last_res, 128'(99));

    // Signed operands.
    n0 = rsp_count;
    issue(0, '1, '1, 2);
    wait_rsp(n0 + 1);
    chk("t4_neg1_sq", last_res, 128'(1));
    n0 = rsp_count;
    issue(1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 3);
    wait_rsp(n0 + 1);
    chk("t4_neg15", last_res, 128'(-15));

    // Stray mul_done while idle is ignored.
    n0 = rsp_count;
    stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("t5_stray_done", 128'(rsp_count), 128'(n0));

    // Early drop of requester 1 while requester 0 is served.
    n0 = rsp_count; g1 = gcnt1;
    issue(0, 64'd10, 64'd10, 6);
    @(posedge clk); #1;
    req_a[2*W-1:W] = 64'd11; req_b[2*W-1:W] = 64'd11; req_valid[1] = 1'b1;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_rsp(n0 + 1);
    repeat (5) @(posedge clk); #1;
    chk("t6_result", last_res, 128'(100));
    chk("t6_no_grant1", 128'(gcnt1), 128'(g1));

    // Reset in the 2nd RUN cycle.
    n0 = rsp_count;
    issue(0, 64'd2, 64'd3, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t7_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("t7_outputs", 128'({req_ready, mul_clear, mul_start, rsp_err}), 128'(0));
    chk("t7_rsp_result", rsp_result, 128'(0));
    chk("t7_mul_ab", 128'({mul_a, mul_b}), 128'(0));
    @(posedge clk); #1;
    chk("t7_no_rsp", 128'(rsp_count), 128'(n0));
    c0 = clr_cnt;
    issue(0, 64'd4, 64'd5, 2);
    wait_rsp(n0 + 1);
    chk("t7_after_result", last_res, 128'(20));
    chk("t7_after_clear", 128'(clr_cnt - c0), 128'(1));

`ifdef MUL_ARBITER_TIMEOUT_EN
    // Timeout: mul_done never arrives.
    n0 = rsp_count; c0 = clr_cnt;
    issue(1, 64'd6, 64'd6, 0);
    wait_rsp(n0 + 1);
    chk("t8_err", 128'(last_err), 128'(1));
    chk("t8_result", last_res, 128'(0));
    chk("t8_vld", 128'(last_vld), 128'(2));
    chk("t8_latency", 128'(rsp_cyc - ready_cyc), 128'(11));
    chk("t8_clear_pulses", 128'(clr_cnt - c0), 128'(2));
`else
    chk("t8_err_const", 128'(last_err), 128'(0));
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 64, giving operand width; products are 2W bits.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum RUN-state wait for mul_done (used only with the timeout feature).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 2 bits: per-requester request valid.
REQ-006 The block SHALL have port req_ready, output, 2 bits: per-requester accept pulse.
REQ-007 The block SHALL have port req_a, input, 2W bits: multiplicands; requester i occupies bits [i*W +: W].
REQ-008 The block SHALL have port req_b, input, 2W bits: multipliers, packed the same way as req_a.
REQ-009 The block SHALL have port rsp_valid, output, 2 bits: one-cycle result-valid pulse per requester.
REQ-010 The block SHALL have port rsp_result, output, 2W bits: registered product.
REQ-011 The block SHALL have port rsp_err, output, 1 bit: timeout error flag, qualified by rsp_valid.
REQ-012 The block SHALL have port mul_clear, output, 1 bit: clears the shared multiplier.
REQ-013 The block SHALL have port mul_start, output, 1 bit: starts the shared multiplier.
REQ-014 The block SHALL have ports mul_a and mul_b, output, W bits each: operands driven to the multiplier.
REQ-015 The block SHALL have port mul_done, input, 1 bit: multiplier completion.
REQ-016 The block SHALL have port mul_result, input, 2W bits: multiplier product.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, RUN, RESP, plus ABORT when the timeout feature is compiled in.
REQ-018 IDLE: when any req_valid bit is set, the block SHALL grant one requester, pulse req_ready[grant] for exactly one cycle, capture that requester's req_a/req_b slices into operand registers, and go to CLEAR.
REQ-019 Arbitration SHALL be round-robin: when both requesters are valid, the one not granted last wins; after reset the last-grant pointer SHALL be 1, so requester 0 wins the first tie.
REQ-020 CLEAR: mul_clear SHALL be 1 for exactly one cycle, then the FSM SHALL go to RUN.
REQ-021 RUN: mul_start SHALL be held at 1 and mul_a/mul_b SHALL hold the captured operands.
REQ-022 RUN: the FSM SHALL sample mul_done each cycle; on the first cycle it is 1, the block SHALL register mul_result into rsp_result and go to RESP.
REQ-023 RESP: rsp_valid[grant] SHALL be 1 for exactly one cycle and mul_start SHALL be 0; the FSM SHALL then return to IDLE.
REQ-024 A new grant SHALL be possible on the cycle after RESP.
REQ-025 Minimum latency from the req_ready pulse to the rsp_valid pulse SHALL be 3 cycles (CLEAR, RUN with mul_done already 1, RESP).
REQ-026 Only one operation SHALL be in flight at a time; req_ready SHALL be 0 in every state other than IDLE.
REQ-027 A requester dropping req_valid before its grant SHALL be treated as no request, with no state change.
REQ-028 A requester SHALL hold its operands stable while req_valid is 1; operands are sampled only in the grant cycle.
REQ-029 mul_done arriving outside RUN SHALL be ignored.
REQ-030 rsp_result SHALL hold its value until the next RESP.

Reset
REQ-031 While reset is 1 at a clock edge: state SHALL go to IDLE; req_ready, rsp_valid, mul_clear, mul_start and rsp_err SHALL be 0; rsp_result, mul_a and mul_b SHALL be 0; the round-robin pointer SHALL be 1.
REQ-032 Reset mid-operation SHALL abandon the operation without any rsp_valid pulse; the next grant SHALL go through CLEAR as usual.

Configuration
REQ-033 With macro MUL_ARBITER_TIMEOUT_EN defined: a cycle counter SHALL run in RUN; if TIMEOUT_CYCLES cycles elapse without mul_done, the FSM SHALL go to ABORT.
REQ-034 ABORT SHALL last one cycle with mul_clear=1 and mul_start=0, followed by RESP with rsp_err=1 and rsp_result=0.
REQ-035 With MUL_ARBITER_TIMEOUT_EN undefined: RUN SHALL wait indefinitely, no counter or ABORT logic SHALL be synthesized, and rsp_err SHALL be constant 0.

Structure
REQ-036 Package mul_arbiter_pkg SHALL hold the FSM state typedef, the default W, and the default TIMEOUT_CYCLES.
REQ-037 A sub-module rr_arb2 SHALL implement the 2-way round-robin grant logic and its pointer register.

Verification
REQ-038 Single request: req_valid=01, a=3, b=5, mul_done after 4 RUN cycles -> one req_ready[0] pulse, one mul_clear pulse, rsp_valid=01 with rsp_result=15.
REQ-039 Tie: req_valid=11 held over two operations -> grants 0 then 1; the second rsp_valid=10 returns requester 1's product.
REQ-040 Signed edge: a=-1, b=-1 (all ones at W=64) with mul_result model -> rsp_result=1.
REQ-041 Reset mid-op: assert reset in the 2nd RUN cycle -> no rsp_valid; all outputs 0 on the next cycle; a following request completes correctly.
REQ-042 Timeout (MUL_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8): mul_done held 0 -> ABORT with mul_clear=1 after 8 RUN cycles, then rsp_valid with rsp_err=1 and rsp_result=0.
REQ-043 Early drop: req_valid[1] pulsed for one cycle while the block is busy serving requester 0 -> requester 1 is never granted.
